// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: rotates the column drive, samples the rows into a
// 16-bit frame and debounces whole frames into a single accepted key with a valid pulse.
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam logic [31:0] DIV_LAST = 32'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [15:0] frame_q, frame_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;

    logic        col_tick;
    logic [4:0]  frame_ones;
    logic [3:0]  frame_code;
    logic        frame_empty;
    logic        frame_single;

    assign col_tick = (div_q == DIV_LAST);

    // Column data is captured at the end of its period so the rows have had a full period to settle.
    always_comb begin
        div_d        = col_tick ? 32'd0 : div_q + 32'd1;
        col_idx_d    = col_tick ? col_idx_q + 2'd1 : col_idx_q;
        frame_d      = frame_q;
        if (col_tick) begin
            frame_d[{col_idx_q, 2'b00} +: 4] = ~keypad_row;
        end
        frame_done_d = col_tick && (col_idx_q == 2'd3);
    end

    always_comb begin
        frame_ones = 5'd0;
        frame_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_q[i]) begin
                frame_ones = frame_ones + 5'd1;
                frame_code = 4'(i);
            end
        end
    end

    assign frame_empty  = (frame_ones == 5'd0);
    assign frame_single = (frame_ones == 5'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= 32'd0;
            col_idx_q    <= 2'd0;
            frame_q      <= 16'd0;
            frame_done_q <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            rcnt_q       <= 4'd0;
            cand_q       <= 4'd0;
            key_code_q   <= 4'd0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            div_q        <= div_d;
            col_idx_q    <= col_idx_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            cand_q       <= cand_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (frame_done_q) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            key_code_d  = frame_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rcnt_d      = 4'd0;
                            state_d     = S_HELD;
                        end else begin
                            state_d = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (frame_single && (frame_code == cand_q)) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB_N) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rcnt_d      = 4'd0;
                            state_d     = S_HELD;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    // Any non-empty frame, even a different key, just restarts the release count.
                    if (frame_empty) begin
                        rcnt_d = rcnt_q + 4'd1;
                        if (rcnt_q + 4'd1 == DEB_N) begin
                            key_held_d = 1'b0;
                            cnt_d      = 4'd0;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        rcnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        keypad_col = ~(4'b0001 << col_idx_q);
        key_code   = key_code_q;
        key_valid  = key_valid_q;
        key_held   = key_held_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-aligned vector table, hand-written reset / mid-frame
// sequences and a randomized key stream checked every clock against a frame-level model.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        reset;
    logic [3:0]  keypad_row;
    logic [3:0]  keypad_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int total;
    int bad;

    // Model state: edges since reset release, last sampled frame and debounce bookkeeping.
    int          m_t;
    logic [15:0] m_frame;
    bit          m_pend;
    bit          m_held;
    int          m_streak;
    int          m_cand;
    int          m_rstreak;
    int          m_code;
    bit          m_valid;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .keypad_row (keypad_row),
        .keypad_col (keypad_col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical key matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        keypad_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!keypad_col[c]) keypad_row = ~pressed[c*4 +: 4];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        int n;
        int code;
        int col;
        if (reset) begin
            m_t = 0; m_frame = '0; m_pend = 0; m_held = 0; m_streak = 0;
            m_cand = 0; m_rstreak = 0; m_code = 0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (m_pend) begin
                n = $countones(m_frame);
                code = 0;
                for (int i = 0; i < 16; i++) if (m_frame[i]) code = i;
                if (!m_held) begin
                    if (n == 1) begin
                        if (m_streak == 0) begin
                            m_cand = code;
                            m_streak = 1;
                        end else if (code == m_cand) begin
                            m_streak++;
                        end else begin
                            m_streak = 0;
                        end
                        if (m_streak == DB) begin
                            m_valid = 1; m_held = 1; m_code = m_cand;
                            m_rstreak = 0; m_streak = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end else if (n == 0) begin
                    m_rstreak++;
                    if (m_rstreak == DB) m_held = 0;
                end else begin
                    m_rstreak = 0;
                end
            end
            m_pend = 0;
            if (m_t % SD == SD - 1) begin
                col = (m_t / SD) % 4;
                m_frame[col*4 +: 4] = pressed[col*4 +: 4];
                m_pend = (col == 3);
            end
            m_t++;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_col;
        @(posedge clk);
        model_edge();
        #1;
        exp_col = ~(4'b0001 << ((m_t / SD) % 4));
        chk("col", int'(keypad_col), int'(exp_col));
        chk("valid", int'(key_valid), int'(m_valid));
        chk("held", int'(key_held), int'(m_held));
        chk("code", int'(key_code), m_code);
    endtask

    // Leaves the bench one edge after release so later frames change keys on frame boundaries.
    task automatic do_reset(input int n);
        reset = 1'b1;
        pressed = '0;
        repeat (n) tick();
        chk("rst_col", int'(keypad_col), 4'b1110);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_code", int'(key_code), 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic run_frames(input logic [15:0] keys, input int frames, output int pulses);
        pressed = keys;
        pulses = 0;
        repeat (frames * FRAME) begin
            tick();
            if (key_valid) pulses++;
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          pulses;
        int          code;
        int          held;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int p;
        int p2;
        logic [3:0] exp_col;
        total = 0;
        bad = 0;
        reset = 1'b1;
        pressed = '0;

        vecs[0]  = '{16'h0000, 2, 0, 0, 0};
        vecs[1]  = '{16'h0200, 3, 1, 9, 1};
        vecs[2]  = '{16'h0220, 2, 0, 9, 1};
        vecs[3]  = '{16'h0000, 2, 0, 9, 1};
        vecs[4]  = '{16'h0200, 1, 0, 9, 1};
        vecs[5]  = '{16'h0000, 3, 0, 9, 0};
        vecs[6]  = '{16'h0200, 2, 0, 9, 0};
        vecs[7]  = '{16'h0000, 1, 0, 9, 0};
        vecs[8]  = '{16'h0200, 3, 1, 9, 1};
        vecs[9]  = '{16'h0000, 3, 0, 9, 0};
        vecs[10] = '{16'h0021, 4, 0, 9, 0};
        vecs[11] = '{16'h0008, 3, 1, 3, 1};
        vecs[12] = '{16'h8000, 2, 0, 3, 1};
        vecs[13] = '{16'h0000, 3, 0, 3, 0};

        do_reset(3);

        for (int t = 1; t <= 2 * FRAME; t++) begin
            tick();
            exp_col = ~(4'b0001 << (((t + 1) / SD) % 4));
            chk("rotate_col", int'(keypad_col), int'(exp_col));
        end

        for (int i = 0; i < 14; i++) begin
            run_frames(vecs[i].keys, vecs[i].frames, p);
            chk($sformatf("vec%0d_pulses", i), p, vecs[i].pulses);
            chk($sformatf("vec%0d_code", i), int'(key_code), vecs[i].code);
            chk($sformatf("vec%0d_held", i), int'(key_held), vecs[i].held);
        end

        // Reset in the middle of debounce (cnt==2) must discard the progress.
        run_frames(16'h0200, 2, p);
        chk("mid_confirm_pulses", p, 0);
        repeat (5) tick();
        do_reset(2);
        run_frames(16'h0200, 2, p);
        chk("after_rst_early", p, 0);
        run_frames(16'h0200, 1, p);
        chk("after_rst_accept", p, 1);
        chk("after_rst_code", int'(key_code), 9);
        run_frames(16'h0000, 3, p);
        chk("after_rst_release", int'(key_held), 0);

        // Key 9 arrives after its column was sampled: that frame stays empty.
        pressed = '0;
        p2 = 0;
        repeat (11) begin tick(); if (key_valid) p2++; end
        pressed = 16'h0200;
        repeat (FRAME - 11) begin tick(); if (key_valid) p2++; end
        run_frames(16'h0200, 2, p);
        chk("midframe_early", p + p2, 0);
        run_frames(16'h0200, 1, p);
        chk("midframe_accept", p, 1);
        run_frames(16'h0000, 3, p);

        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) pressed = '0;
            else if (r < 3) pressed = 16'h0001 << $urandom_range(0, 15);
            else pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            repeat ($urandom_range(10, 120)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the game's 8x8 dot-matrix row scanner. The display scanner drives rows out; this block drives the columns of a 4x4 active-low key matrix and samples its rows back. It debounces the samples and reports a single pressed key as a 4-bit code with a one-clock valid pulse. It feeds player-action logic as an alternative to the discrete left/right buttons.

## Interface
- SCAN_DIV, 25000: clk cycles spent on each column; minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix scans needed to accept a press or a release; minimum 1, maximum 15.
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- keypad_row  in  4  row sense lines, pulled up externally; 0 means the key on the driven column is pressed.
- keypad_col  out  4  column drive, active-low, exactly one bit low at a time.
- key_code  out  4  last accepted key, equal to col_idx*4 + row_idx.
- key_valid  out  1  one-clock pulse when a new key is accepted.
- key_held  out  1  high while the accepted key is considered held.

## Operation
- **Divider:** div counts 0..SCAN_DIV-1 and wraps.
- **Column advance:** at div==SCAN_DIV-1, col_idx increments mod 4.
- **Column drive:** keypad_col = ~(1<<col_idx). Column 0 is 4'b1110.
- **Sampling:** ~keypad_row is captured into frame bits [col_idx*4+3 : col_idx*4] on the same edge as the column advance (div==SCAN_DIV-1), giving the lines a full column period to settle.
- **Frame completion:** the edge that captures column 3 completes the 16-bit frame. frame_done is registered high for the next single clock.
- **Frame classes:** EMPTY (0 bits set), SINGLE (exactly 1 bit set; code = index of that bit, with bit n meaning col n/4, row n%4), MULTI (2 or more bits set).
- **FSM:** evaluated only on clocks where frame_done=1.
  - **IDLE:**
    - SINGLE: cand<=code, cnt<=1. If DEBOUNCE_SCANS==1, accept immediately (see acceptance below); otherwise go to CONFIRM.
    - EMPTY or MULTI: stay in IDLE.
  - **CONFIRM:**
    - SINGLE with code==cand: cnt<=cnt+1. When cnt+1==DEBOUNCE_SCANS, accept.
    - Any other frame (EMPTY, MULTI, or a different single key): go to IDLE, cnt<=0.
  - **Acceptance:** key_code<=cand, key_valid<=1 for exactly one clock, key_held<=1, state<=HELD, rcnt<=0.
  - **HELD:**
    - EMPTY: rcnt<=rcnt+1. When rcnt+1==DEBOUNCE_SCANS, go to IDLE, key_held<=0, cnt<=0.
    - SINGLE or MULTI: rcnt<=0 and stay in HELD. There is no auto-repeat and no second valid pulse, even if the held key changes.
- **key_code hold:** key_code keeps its last accepted value through release and IDLE.

## Timing
- **Reset values:** div=0, col_idx=0, keypad_col=4'b1110, frame=0, frame_done=0, state=IDLE, cnt=0, rcnt=0, key_code=0, key_valid=0, key_held=0.
- **Reset priority:** reset asserted mid-debounce or mid-hold overrides everything on that edge. No key_valid pulse is produced on the reset edge or on the clock after it.
- **Frame period:** 4*SCAN_DIV clocks.
- **Press latency:** a press that is stable across the whole frame is accepted on the DEBOUNCE_SCANS-th qualifying frame_done clock. key_valid rises on the edge after that frame_done, and key_held rises on the same edge.
- **Release latency:** key_held falls on the edge after the DEBOUNCE_SCANS-th consecutive EMPTY frame_done.
- **Mid-frame change:** a key pressed or released mid-frame counts only for the columns sampled after the change. A frame sampled while the key is absent from its column is EMPTY.
- **Counter widths:** cnt and rcnt are 4 bits and never exceed DEBOUNCE_SCANS.
- **Divider width:** div is 32 bits.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-clock frame.
- **Reset and column rotation:** hold reset for 3 clocks, then release with keypad_row=4'hF -> keypad_col=4'b1110 for 4 clocks, then 1101, 1011, 0111, repeating. key_valid and key_held stay 0 indefinitely.
- **Single-key accept:** model key col 2 / row 1 held steady, so keypad_row=4'b1101 while keypad_col=4'b1011 -> exactly one key_valid pulse with key_code=9 on the clock after the 3rd frame_done, and key_held=1 from the same clock.
- **Bounce rejection:** key 9 present for frames 1 and 2, absent in frame 3, present in frames 4, 5 and 6 -> no pulse after frame 3. key_valid pulses once, one clock after frame 6.
- **Release:** after the single-key accept, release the key -> key_held falls the clock after the 3rd EMPTY frame_done. An interleaved non-empty frame restarts the release count.
- **Multi-key:** keys 0 and 5 pressed together from IDLE -> no key_valid ever. Pressing key 5 while key 9 is HELD -> no new pulse and key_code stays 9.
- **Reset mid-debounce:** assert reset during CONFIRM with cnt=2 -> all outputs return to reset values and keypad_col=4'b1110. After release, a fresh press needs a full 3 frames before key_valid pulses.
